mul_hilo_unit: RTL and testbench
================================

# mul_hilo_unit

Multi-cycle signed multiplier with the architectural HI/LO register pair, downstream of the multiply-control decoder. It consumes the decoder's four control signals plus the two GPR read operands. It executes MULT, MTHI, MTLO, MFHI and MFLO, and returns the selected HI/LO value to the register write-back mux. While a multiply is in flight it raises a stall request for the pipeline.

## Interface
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `mul_ctr`  in  1  decoder start-multiply (MULT)
- `reg_to_mul`  in  2  write select: 00 none, 01 MTLO, 10 MTHI, 11 MULT operands
- `mul_to_reg`  in  1  instruction reads HI/LO into a GPR (MFHI/MFLO)
- `mul_read`  in  1  read select: 0 LO, 1 HI
- `rs_data`  in  32  first operand; also the MTHI/MTLO source
- `rt_data`  in  32  second operand
- `mul_out`  out  32  `mul_read ? HI : LO`, combinational
- `busy`  out  1  multiply in progress (registered state, not IDLE)
- `done`  out  1  one-cycle pulse in the final (write-back) cycle
- `stall`  out  1  `busy & (mul_ctr | (reg_to_mul != 00) | mul_to_reg)`, combinational

## Operation
- **State machine** has three states: IDLE, RUN, FIN. A 6-bit counter `cnt` and the following registers are kept:
  - HI and LO, 32 bits each
  - `mcand`, 64 bits: the multiplicand magnitude, shifted left each step
  - `mplier`, 32 bits: the multiplier magnitude, shifted right each step
  - `acc`, 64 bits
  - `neg`, 1 bit
- **Start.** In IDLE, `mul_ctr=1` and `reg_to_mul=11` together start a multiply. On that edge:
  - `mcand` <= zero-extended `|rs_data|`; `mplier` <= `|rt_data|`; `acc` <= 0
  - `neg` <= `rs_data[31] ^ rt_data[31]`; `cnt` <= 0; state <= RUN
  - Magnitude is the two's-complement absolute value; `|0x80000000|` = 0x80000000 unsigned, with no overflow.
- **RUN**, one step per cycle:
  - if `mplier[0]`, then `acc` <= `acc + mcand`
  - `mcand` <= `mcand << 1`; `mplier` <= `mplier >> 1`; `cnt` <= `cnt + 1`
  - After the step with `cnt == 31`, state <= FIN.
- **FIN.** `done=1` for this cycle. On the closing edge, `{HI,LO}` <= `neg ? -acc : acc` (64-bit two's complement) and state <= IDLE.
- **MTHI/MTLO.** In IDLE, `reg_to_mul=10` writes `rs_data` to HI, or `reg_to_mul=01` writes it to LO, on the edge. The other register is unchanged.
- **MFHI/MFLO.** `mul_out` is always driven. The consumer samples it only when `mul_to_reg=1` and `stall=0`.
- **While busy**, every control input is ignored: no new MULT, no MT write. HI and LO keep their pre-MULT values until the FIN edge, and `stall` holds the requesting instruction. Once `busy` falls, the held instruction is re-presented and acts normally.
- **Reset** takes priority over everything, including mid-RUN or FIN. On the reset edge:
  - HI = LO = 0; state = IDLE; `cnt`, `acc`, `mcand`, `mplier` and `neg` = 0
  - The aborted multiply writes nothing.
- **Outputs after reset:** `busy=0`, `done=0`, `mul_out=0`, and `stall` follows its equation, so it is 0 with no requests.

## Timing
- Call the MULT acceptance edge E0.
- `busy=1` from the cycle after E0 through the FIN cycle: exactly 33 cycles (32 RUN + 1 FIN).
- `done=1` in cycle 33 only. HI/LO hold the new result from edge E33 onward, so MFHI/MFLO in the cycle after `done` sees it.
- Back-to-back MULT is accepted at the earliest on E34, the first IDLE edge. Total throughput is 34 cycles per MULT.
- MT writes have a latency of 1 edge. `mul_out` reflects them in the next cycle, with no same-cycle bypass.
- `stall` and `mul_out` are pure combinational functions of the current state and inputs, with no registered delay.

## Test plan
- **Reset, then idle.** Assert `reset` for 2 cycles with `mul_read` 0 then 1 → `mul_out=0x00000000` both times; `busy=0`; `done=0`; `stall=0`.
- **Signed product.** MULT with `rs=7`, `rt=0xFFFFFFFD` (−3) → `busy` high exactly 33 cycles and `done` pulses in cycle 33. Afterwards HI=0xFFFFFFFF and LO=0xFFFFFFEB.
- **Corner operands.** MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000. MULT 0xFFFFFFFF × 0x00000001 → HI=0xFFFFFFFF, LO=0xFFFFFFFF. MULT 0 × 0x12345678 → both 0.
- **Moves.** MTHI 0x12345678, then MTLO 0x9ABCDEF0 → `mul_read=1` gives 0x12345678 and `mul_read=0` gives 0x9ABCDEF0. Neither write disturbs the other register.
- **Hazard while busy.** During RUN, present MFLO, then MTHI 0xDEADBEEF, then a second MULT → each presentation gives `stall=1`, and each is ignored. HI/LO are unchanged until FIN, and `stall=0` in the cycle after `done`.
- **Reset mid-operation.** Start MULT 5 × 6 and assert `reset` in RUN cycle 10 → state IDLE next cycle, `busy=0`, HI=LO=0, and `done` never pulses.

Source files
------------

// File: rtl/mul_hilo_unit_if.sv
// rtl/mul_hilo_unit_if.sv - decoder/GPR-side bus of the multiplier and HI/LO pair
interface mul_hilo_unit_if;
    logic        mul_ctr;
    logic [1:0]  reg_to_mul;
    logic        mul_to_reg;
    logic        mul_read;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] mul_out;
    logic        busy;
    logic        done;
    logic        stall;

    modport master (
        output mul_ctr, reg_to_mul, mul_to_reg, mul_read, rs_data, rt_data,
        input  mul_out, busy, done, stall
    );

    modport slave (
        input  mul_ctr, reg_to_mul, mul_to_reg, mul_read, rs_data, rt_data,
        output mul_out, busy, done, stall
    );
endinterface

// File: rtl/mul_hilo_unit.sv
// rtl/mul_hilo_unit.sv - 34-cycle shift-add signed multiplier with HI/LO registers
module mul_hilo_unit (
    input  logic           clk,
    input  logic           reset,
    mul_hilo_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    state_t      state, nextState;
    logic [5:0]  cnt;
    logic [31:0] hi, lo;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic        neg;

    logic        startMul;
    logic [31:0] rsMag, rtMag;
    logic [63:0] product;

    assign startMul = (state == IDLE) && bus.mul_ctr && (bus.reg_to_mul == 2'b11);

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign rsMag   = bus.rs_data[31] ? (~bus.rs_data + 32'd1) : bus.rs_data;
    assign rtMag   = bus.rt_data[31] ? (~bus.rt_data + 32'd1) : bus.rt_data;
    assign product = neg ? (~acc + 64'd1) : acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.stall   = 1'b0;
        bus.mul_out = bus.mul_read ? hi : lo;
        case (state)
            IDLE: begin
                if (startMul) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (cnt == 6'd31) begin
                    nextState = FIN;
                end
            end
            FIN: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        bus.stall = bus.busy & (bus.mul_ctr | (bus.reg_to_mul != 2'b00) | bus.mul_to_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 6'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            acc    <= 64'd0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startMul) begin
                        mcand  <= {32'd0, rsMag};
                        mplier <= rtMag;
                        acc    <= 64'd0;
                        neg    <= bus.rs_data[31] ^ bus.rt_data[31];
                        cnt    <= 6'd0;
                    end else if (bus.reg_to_mul == 2'b10) begin
                        hi <= bus.rs_data;
                    end else if (bus.reg_to_mul == 2'b01) begin
                        lo <= bus.rs_data;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                end
                FIN: begin
                    {hi, lo} <= product;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb/tb_mul_hilo_unit.sv - directed scoreboard bench for mul_hilo_unit
module tb_mul_hilo_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] modelHi, modelLo;
    logic [63:0] sb[$];

    mul_hilo_unit_if bus();

    mul_hilo_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        bus.mul_ctr    = 1'b0;
        bus.reg_to_mul = 2'b00;
        bus.mul_to_reg = 1'b0;
        bus.mul_read   = 1'b0;
        bus.rs_data    = 32'd0;
        bus.rt_data    = 32'd0;
    endtask

    task automatic checkHiLo(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
        bus.mul_read = 1'b1;
        #1;
        check({tag, "_hi"}, {32'd0, bus.mul_out}, {32'd0, expHi});
        bus.mul_read = 1'b0;
        #1;
        check({tag, "_lo"}, {32'd0, bus.mul_out}, {32'd0, expLo});
    endtask

    task automatic runMult(input string tag, input logic [31:0] a, input logic [31:0] b, input bit hazard);
        logic signed [63:0] p;
        logic [63:0] exp;
        int busyCnt, doneCnt, doneAt;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        sb.push_back(p);
        @(negedge clk);
        bus.mul_ctr    = 1'b1;
        bus.reg_to_mul = 2'b11;
        bus.rs_data    = a;
        bus.rt_data    = b;
        @(negedge clk);
        idleInputs();
        busyCnt = 0;
        doneCnt = 0;
        doneAt  = 0;
        for (int i = 1; i <= 40; i++) begin
            if (hazard) begin
                idleInputs();
                if (i == 2) bus.mul_to_reg = 1'b1;
                if (i == 3) begin
                    bus.reg_to_mul = 2'b10;
                    bus.rs_data    = 32'hDEADBEEF;
                end
                if (i == 4) begin
                    bus.mul_ctr    = 1'b1;
                    bus.reg_to_mul = 2'b11;
                    bus.rs_data    = 32'd9;
                    bus.rt_data    = 32'd9;
                end
                if (i == 10) bus.mul_read = 1'b1;
            end
            #1;
            if (hazard && i >= 2 && i <= 4) check($sformatf("%s_stall_c%0d", tag, i), {63'd0, bus.stall}, 64'd1);
            if (hazard && i == 2) check({tag, "_mflo_old"}, {32'd0, bus.mul_out}, {32'd0, modelLo});
            if (hazard && i == 10) check({tag, "_hi_held"}, {32'd0, bus.mul_out}, {32'd0, modelHi});
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                doneCnt++;
                doneAt = i;
            end
            if (!bus.busy) break;
            @(negedge clk);
        end
        idleInputs();
        if (hazard) begin
            bus.mul_to_reg = 1'b1;
            #1;
            check({tag, "_stall_after"}, {63'd0, bus.stall}, 64'd0);
            bus.mul_to_reg = 1'b0;
        end
        check({tag, "_busy_cycles"}, 64'(busyCnt), 64'd33);
        check({tag, "_done_count"}, 64'(doneCnt), 64'd1);
        check({tag, "_done_cycle"}, 64'(doneAt), 64'd33);
        exp = sb.pop_front();
        modelHi = exp[63:32];
        modelLo = exp[31:0];
        checkHiLo(tag, modelHi, modelLo);
    endtask

    initial begin
        int doneSeen;
        total = 0;
        bad   = 0;
        idleInputs();
        reset = 1'b1;

        @(negedge clk);
        bus.mul_read = 1'b0;
        #1;
        check("rst_mul_out_lo", {32'd0, bus.mul_out}, 64'd0);
        @(negedge clk);
        bus.mul_read = 1'b1;
        #1;
        check("rst_mul_out_hi", {32'd0, bus.mul_out}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_stall", {63'd0, bus.stall}, 64'd0);
        reset   = 1'b0;
        modelHi = 32'd0;
        modelLo = 32'd0;
        bus.mul_read = 1'b0;

        runMult("m7xm3", 32'd7, 32'hFFFFFFFD, 1'b0);
        check("m7xm3_const_hi", {32'd0, modelHi}, 64'h0000_0000_FFFF_FFFF);
        check("m7xm3_const_lo", {32'd0, modelLo}, 64'h0000_0000_FFFF_FFEB);
        runMult("min_sq", 32'h80000000, 32'h80000000, 1'b0);
        runMult("neg1x1", 32'hFFFFFFFF, 32'h00000001, 1'b0);
        runMult("zero", 32'h00000000, 32'h12345678, 1'b0);

        @(negedge clk);
        bus.reg_to_mul = 2'b10;
        bus.rs_data    = 32'h12345678;
        bus.mul_read   = 1'b1;
        #1;
        check("mthi_no_bypass", {32'd0, bus.mul_out}, {32'd0, modelHi});
        @(negedge clk);
        modelHi = 32'h12345678;
        bus.reg_to_mul = 2'b01;
        bus.rs_data    = 32'h9ABCDEF0;
        bus.mul_read   = 1'b0;
        #1;
        check("mtlo_no_bypass", {32'd0, bus.mul_out}, {32'd0, modelLo});
        @(negedge clk);
        modelLo = 32'h9ABCDEF0;
        idleInputs();
        checkHiLo("moves", 32'h12345678, 32'h9ABCDEF0);

        runMult("hazard", 32'd3, 32'd4, 1'b1);
        check("sb_empty", 64'(sb.size()), 64'd0);

        @(negedge clk);
        bus.mul_ctr    = 1'b1;
        bus.reg_to_mul = 2'b11;
        bus.rs_data    = 32'd5;
        bus.rt_data    = 32'd6;
        @(negedge clk);
        idleInputs();
        doneSeen = 0;
        for (int i = 1; i < 10; i++) begin
            if (bus.done) doneSeen++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        checkHiLo("abort", 32'd0, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) doneSeen++;
        end
        check("abort_no_done", 64'(doneSeen), 64'd0);
        check("abort_idle_busy", {63'd0, bus.busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
